// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - MSB-first parallel-to-serial pattern generator with repeat, stall, abort and done pulse

module seq_serializer #(
   parameter int WIDTH = 16,
   parameter int LEN_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LEN_W-1:0] load_len,
   input  logic             repeat_en,
   input  logic             step_en,
   input  logic             abort,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic [3:0]       seq
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_data;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_cnt;
   logic [3:0]         r_seq;

   logic               w_accept;
   logic               w_consume;
   logic               w_last;
   logic [LEN_W-1:0]   w_len_clamped;
   logic [LEN_W-1:0]   w_idx;
   logic               w_bit;

   // Lengths above the register width are clamped; a zero length goes straight to DONE.
   assign w_len_clamped = (load_len > WIDTH_L) ? WIDTH_L : load_len;

   // Accept only in IDLE; abort in the same cycle does not cancel the accept.
   assign w_accept  = (r_state == S_IDLE) && load_valid;
   // Abort suppresses consumption so seq keeps the bits seen before the abort.
   assign w_consume = (r_state == S_SHIFT) && step_en && !abort;
   assign w_last    = w_consume && (r_cnt == LEN_W'(1));
   assign w_idx     = r_cnt - LEN_W'(1);

   // Select data[cnt-1] with a compare loop so the index width never has to match WIDTH.
   always_comb begin
      w_bit = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_idx == LEN_W'(i)) begin
            w_bit = r_data[i];
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = (w_len_clamped == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               w_next = S_IDLE;
            end else if (w_last && !repeat_en) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Pattern, length, bit counter and consumed-bit history.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_len  <= '0;
         r_cnt  <= '0;
         r_seq  <= '0;
      end else if (w_accept) begin
         r_data <= load_data;
         r_len  <= w_len_clamped;
         r_cnt  <= w_len_clamped;
         r_seq  <= '0;
      end else if (w_consume) begin
         r_seq <= {r_seq[2:0], w_bit};
         if (w_last && repeat_en) begin
            r_cnt <= r_len;
         end else begin
            r_cnt <= w_idx;
         end
      end
   end

   // Outputs are pure state decodes; out is forced low outside SHIFT.
   always_comb begin
      load_ready = (r_state == S_IDLE);
      out_valid  = (r_state == S_SHIFT);
      out        = (r_state == S_SHIFT) ? w_bit : 1'b0;
      busy       = (r_state != S_IDLE);
      done       = (r_state == S_DONE);
      seq        = r_seq;
   end

endmodule

// File: tb/tb_seq_serializer.sv
// tb/tb_seq_serializer.sv - directed self-checking bench for seq_serializer

module tb_seq_serializer;

   logic        clk;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic [4:0]  load_len;
   logic        repeat_en;
   logic        step_en;
   logic        abort;
   logic        out;
   logic        out_valid;
   logic        busy;
   logic        done;
   logic [3:0]  seq;

   int checks = 0;
   int errors = 0;

   // 35A6 with len 14, MSB first
   logic [13:0] exp14;

   seq_serializer #(.WIDTH(16), .LEN_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_len   (load_len),
      .repeat_en  (repeat_en),
      .step_en    (step_en),
      .abort      (abort),
      .out        (out),
      .out_valid  (out_valid),
      .busy       (busy),
      .done       (done),
      .seq        (seq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a load for one edge; the block is expected to be IDLE.
   task automatic do_load(input logic [15:0] d, input logic [4:0] l);
      load_data  = d;
      load_len   = l;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({load_ready, out, out_valid, busy, done, seq} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b out=%b ov=%b busy=%b done=%b seq=%h, want 1 0 0 0 0 0",
                  load_ready, out, out_valid, busy, done, seq);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      step_en = 1'b1;
      repeat_en = 1'b0;
      do_load(16'h35A6, 5'd14);
      for (int i = 0; i < 14; i++) begin
         checks++;
         if (out !== exp14[13-i] || out_valid !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_bit%0d: got out=%b ov=%b done=%b, want out=%b ov=1 done=0",
                     i + 1, out, out_valid, done, exp14[13-i]);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || out !== 1'b0 || busy !== 1'b1 || load_ready !== 1'b0 || seq !== 4'h6) begin
         errors++;
         $display("FAIL basic_done: got done=%b ov=%b out=%b busy=%b rdy=%b seq=%h, want 1 0 0 1 0 6",
                  done, out_valid, out, busy, load_ready, seq);
      end
      tick();
      checks++;
      if (load_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || seq !== 4'h6) begin
         errors++;
         $display("FAIL basic_idle: got rdy=%b done=%b busy=%b seq=%h, want 1 0 0 6", load_ready, done, busy, seq);
      end
   endtask

   task automatic test_stall();
      int idx;
      step_en = 1'b1;
      repeat_en = 1'b0;
      do_load(16'h35A6, 5'd14);
      for (int c = 1; c <= 17; c++) begin
         idx = (c <= 2) ? c : ((c <= 5) ? 2 : c - 3);
         checks++;
         if (out !== exp14[14-idx] || out_valid !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL stall_cycle%0d: got out=%b ov=%b done=%b, want out=%b ov=1 done=0",
                     c, out, out_valid, done, exp14[14-idx]);
         end
         step_en = !(c >= 2 && c <= 4);
         tick();
      end
      checks++;
      if (done !== 1'b1 || seq !== 4'h6) begin
         errors++;
         $display("FAIL stall_done18: got done=%b seq=%h, want 1 6", done, seq);
      end
      step_en = 1'b1;
      tick();
   endtask

   task automatic test_repeat();
      logic [7:0] exp8;
      exp8 = 8'b1011_1011;
      step_en = 1'b1;
      repeat_en = 1'b1;
      do_load(16'h000B, 5'd4);
      for (int c = 1; c <= 8; c++) begin
         checks++;
         if (out !== exp8[8-c] || out_valid !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL repeat_cycle%0d: got out=%b ov=%b done=%b, want out=%b ov=1 done=0",
                     c, out, out_valid, done, exp8[8-c]);
         end
         if (c == 5) repeat_en = 1'b0;
         tick();
      end
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || seq !== 4'hB) begin
         errors++;
         $display("FAIL repeat_done: got done=%b ov=%b seq=%h, want 1 0 b", done, out_valid, seq);
      end
      tick();
   endtask

   task automatic test_abort_reset();
      step_en = 1'b1;
      repeat_en = 1'b0;
      do_load(16'h35A6, 5'd14);
      repeat (4) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out !== 1'b0 || done !== 1'b0 || seq !== 4'hD) begin
         errors++;
         $display("FAIL abort_idle: got busy=%b ov=%b out=%b done=%b seq=%h, want 0 0 0 0 d",
                  busy, out_valid, out, done, seq);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL abort_nodone: got done=%b, want 0", done);
      end
      do_load(16'h35A6, 5'd14);
      repeat (4) tick();
      rst = 1'b1;
      load_valid = 1'b1;
      tick();
      checks++;
      if ({load_ready, out, out_valid, busy, done, seq} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}) begin
         errors++;
         $display("FAIL midreset: got rdy=%b out=%b ov=%b busy=%b done=%b seq=%h, want 1 0 0 0 0 0",
                  load_ready, out, out_valid, busy, done, seq);
      end
      rst = 1'b0;
      load_valid = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_noaccept: got busy=%b, want 0", busy);
      end
      abort = 1'b1;
      do_load(16'h35A6, 5'd14);
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b1 || out !== 1'b1) begin
         errors++;
         $display("FAIL abort_vs_accept: got busy=%b ov=%b out=%b, want 1 1 1", busy, out_valid, out);
      end
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_after_accept: got busy=%b, want 0", busy);
      end
      tick();
   endtask

   task automatic test_length_edges();
      int nvalid;
      step_en = 1'b1;
      repeat_en = 1'b0;
      do_load(16'hFFFF, 5'd0);
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || out !== 1'b0) begin
         errors++;
         $display("FAIL len0_done: got done=%b ov=%b out=%b, want 1 0 0", done, out_valid, out);
      end
      tick();
      checks++;
      if (load_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL len0_idle: got rdy=%b ov=%b done=%b, want 1 0 0", load_ready, out_valid, done);
      end
      do_load(16'h8001, 5'd20);
      nvalid = 0;
      for (int c = 1; c <= 16; c++) begin
         if (c == 3) begin
            load_data  = 16'h0005;
            load_len   = 5'd3;
            load_valid = 1'b1;
         end
         if (out_valid === 1'b1) nvalid++;
         checks++;
         if (out !== ((c == 1 || c == 16) ? 1'b1 : 1'b0) || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL len20_bit%0d: got out=%b rdy=%b, want out=%b rdy=0",
                     c, out, load_ready, (c == 1 || c == 16));
         end
         tick();
      end
      checks++;
      if (nvalid !== 16 || done !== 1'b1) begin
         errors++;
         $display("FAIL len20_count: got %0d bits done=%b, want 16 bits done=1", nvalid, done);
      end
      tick();
      tick();
      load_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out !== 1'b1 || seq !== 4'h0) begin
         errors++;
         $display("FAIL held_load_accept: got ov=%b out=%b seq=%h, want 1 1 0", out_valid, out, seq);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
   endtask

   task automatic test_loopback();
      logic [2:0]  hist;
      logic        det;
      logic [13:0] exp_det;
      exp_det = 14'b00000010000000;
      hist = 3'b000;
      step_en = 1'b1;
      repeat_en = 1'b0;
      do_load(16'h35A6, 5'd14);
      for (int c = 1; c <= 14; c++) begin
         det = out_valid && step_en && (hist == 3'b101) && out;
         checks++;
         if (det !== exp_det[14-c] || (c >= 4 && seq[2:0] !== hist)) begin
            errors++;
            $display("FAIL loopback_cycle%0d: got det=%b seq=%h, want det=%b seq[2:0]=%b",
                     c, det, seq, exp_det[14-c], hist);
         end
         if (out_valid && step_en) hist = {hist[1:0], out};
         tick();
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL loopback_done: got done=%b, want 1", done);
      end
      tick();
   endtask

   initial begin
      exp14      = 14'b11010110100110;
      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      load_len   = '0;
      repeat_en  = 1'b0;
      step_en    = 1'b0;
      abort      = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_repeat();
      test_abort_reset();
      test_length_edges();
      test_loopback();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
